// File: rtl/calc_display_sequencer_pkg.sv
// calc_display_sequencer_pkg
// Shared types and constants for the calculator display sequencer:
//   state_t      - sequencer FSM states
//   BCD_DIGITS   - number of FND digits driven
//   NIBBLE_W     - width of one BCD digit
//   BCD_W        - width of the packed BCD result
//   MAX_DATA_W   - widest binary result that still fits in BCD_DIGITS digits
//   add3_digits  - shift-add-3 correction applied before every shift
package calc_display_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CONV = 2'd2,
        SHOW = 2'd3
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int BCD_W      = BCD_DIGITS * NIBBLE_W;
    localparam int MAX_DATA_W = 13;

    // Any digit that is 5 or more would overflow past 9 when doubled by the
    // next shift, so it is pre-corrected by 3 to carry into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adjusted;
        adjusted = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
                adjusted[i*NIBBLE_W +: NIBBLE_W] = bcd[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
            end
        end
        return adjusted;
    endfunction

endpackage

// File: rtl/calc_display_sequencer_bin2bcd.sv
// bin2bcd_seq
// Iterative binary-to-BCD converter (shift-add-3), one bit per clock.
// Ports:
//   i_clk   - clock, all state on rising edge
//   i_reset - synchronous active-high reset
//   i_load  - capture i_bin and start a conversion (clears the BCD accumulator)
//   i_bin   - binary value to convert
//   o_busy  - high while shifts remain
//   o_done  - one-cycle pulse in the cycle after the final shift
//   o_bcd   - packed BCD result, valid when o_done pulses
module bin2bcd_seq
    import calc_display_sequencer_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_bin,
    output logic              o_busy,
    output logic              o_done,
    output logic [BCD_W-1:0]  o_bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]       bin_q;
    logic [CNT_W-1:0]        shift_cnt;
    logic [BCD_W+DATA_W-1:0] shifted;

    // Correct the BCD digits, then move the next binary bit into digit 0.
    assign shifted = {add3_digits(o_bcd), bin_q} << 1;

    // The counter starts at DATA_W; busy and done flip on the edge that
    // performs the last shift so the result is ready when done is seen.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bin_q     <= '0;
            o_bcd     <= '0;
            shift_cnt <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_load) begin
                bin_q     <= i_bin;
                o_bcd     <= '0;
                shift_cnt <= CNT_W'(DATA_W);
                o_busy    <= 1'b1;
            end else if (o_busy) begin
                o_bcd     <= shifted[BCD_W+DATA_W-1:DATA_W];
                bin_q     <= shifted[DATA_W-1:0];
                shift_cnt <= shift_cnt - CNT_W'(1);
                if (shift_cnt == CNT_W'(1)) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_display_sequencer.sv
// calc_display_sequencer
// Runs one calculator operation through the shared datapath, converts the
// binary result to BCD and continuously scans it onto a 4-digit FND with
// leading-zero blanking.
// Ports:
//   i_clk, i_reset               - clock and synchronous active-high reset
//   i_start / o_ready            - start handshake, accepted when both high
//   i_a, i_b, i_selOperator      - operands and operator for the next run
//   o_a, o_b, o_selOperator      - latched operands/operator to the datapath
//   i_result                     - datapath result, valid CALC_LAT cycles on
//   o_busy                       - high while executing or converting
//   o_done                       - one-cycle pulse when the display updates
//   o_digitSelect, o_value, o_en - registered digit index, BCD nibble, enable
module calc_display_sequencer
    import calc_display_sequencer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CALC_LAT    = 1,
    parameter int REFRESH_DIV = 100000
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_selOperator,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [1:0]        o_selOperator,
    input  logic [DATA_W-1:0] i_result,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_digitSelect,
    output logic [3:0]        o_value,
    output logic              o_en
);

    generate
        if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_width
            $error("calc_display_sequencer: DATA_W must be 1..13");
        end
    endgenerate

    localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [BCD_W-1:0]   disp;
    logic               disp_valid;
    logic [REF_W-1:0]   refresh_cnt;
    logic [1:0]         digit_idx;

    logic               exec_last;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [NIBBLE_W-1:0] cur_nibble;
    logic               digit_on;

    assign o_ready   = (state == IDLE) || (state == SHOW);
    assign exec_last = (state == EXEC) && (lat_cnt == LAT_W'(CALC_LAT - 1));

    // The converter loads i_result directly on the final EXEC edge, so no
    // extra capture register sits between the datapath and the engine.
    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (exec_last),
        .i_bin   (i_result),
        .o_busy  (conv_busy),
        .o_done  (conv_done),
        .o_bcd   (conv_bcd)
    );

    // Sequencer: a start in SHOW relaunches while the old result stays on
    // the display until the new conversion finishes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            o_a           <= '0;
            o_b           <= '0;
            o_selOperator <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            disp          <= '0;
            disp_valid    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    if (i_start) begin
                        o_a           <= i_a;
                        o_b           <= i_b;
                        o_selOperator <= i_selOperator;
                        lat_cnt       <= '0;
                        o_busy        <= 1'b1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        state <= CONV;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                CONV: begin
                    // The engine drops busy on the same edge it raises done.
                    if (conv_done && !conv_busy) begin
                        disp       <= conv_bcd;
                        disp_valid <= 1'b1;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit enable: digit 0 always shows once valid, higher digits only if
    // they or any more significant digit are nonzero.
    always_comb begin
        cur_nibble = disp[digit_idx*NIBBLE_W +: NIBBLE_W];
        digit_on   = (digit_idx == 2'd0);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (2'(i) >= digit_idx && disp[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                digit_on = 1'b1;
            end
        end
    end

    // Scanner runs in every state; outputs lag the index by one register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            refresh_cnt   <= '0;
            digit_idx     <= '0;
            o_digitSelect <= '0;
            o_value       <= '0;
            o_en          <= 1'b0;
        end else begin
            if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            o_digitSelect <= digit_idx;
            o_value       <= cur_nibble;
            o_en          <= disp_valid && digit_on;
        end
    end

endmodule

// File: tb/tb_calc_display_sequencer.sv
// tb_calc_display_sequencer
// Directed bench: an a+b datapath model feeds a CALC_LAT=1 instance, and a
// second CALC_LAT=3 instance sees X from its model until the result is due.
module tb_calc_display_sequencer;

    localparam int DATA_W      = 8;
    localparam int REFRESH_DIV = 4;
    localparam int NCAP        = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 (CALC_LAT = 1)
    logic        reset, start, ready, busy, done, en;
    logic [7:0]  a, b, oa, ob, result;
    logic [1:0]  sel, osel, dsel;
    logic [3:0]  value;

    // Instance 2 (CALC_LAT = 3)
    logic        reset2, start2, ready2, busy2, done2, en2;
    logic [7:0]  a2, b2, oa2, ob2, result2;
    logic [1:0]  sel2, osel2, dsel2;
    logic [3:0]  value2;
    int          launch_cnt = 15;

    int total = 0;
    int bad   = 0;

    logic [1:0] cap_sel [NCAP];
    logic [3:0] cap_val [NCAP];
    logic       cap_en  [NCAP];

    assign result = oa + ob;

    // Slow datapath: result is unknown until its last latency cycle.
    always @(posedge clk) begin
        if (reset2)                launch_cnt <= 15;
        else if (start2 && ready2) launch_cnt <= 0;
        else if (launch_cnt < 15)  launch_cnt <= launch_cnt + 1;
    end
    assign result2 = (launch_cnt >= 2) ? oa2 + ob2 : 8'hxx;

    calc_display_sequencer #(.DATA_W(DATA_W), .CALC_LAT(1), .REFRESH_DIV(REFRESH_DIV)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .o_ready(ready),
        .i_a(a), .i_b(b), .i_selOperator(sel),
        .o_a(oa), .o_b(ob), .o_selOperator(osel), .i_result(result),
        .o_busy(busy), .o_done(done),
        .o_digitSelect(dsel), .o_value(value), .o_en(en)
    );

    calc_display_sequencer #(.DATA_W(DATA_W), .CALC_LAT(3), .REFRESH_DIV(REFRESH_DIV)) dut2 (
        .i_clk(clk), .i_reset(reset2), .i_start(start2), .o_ready(ready2),
        .i_a(a2), .i_b(b2), .i_selOperator(sel2),
        .o_a(oa2), .o_b(ob2), .o_selOperator(osel2), .i_result(result2),
        .o_busy(busy2), .o_done(done2),
        .o_digitSelect(dsel2), .o_value(value2), .o_en(en2)
    );

    function automatic int pow10(input int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] dig(input int v, input int i);
        return 4'((v / pow10(i)) % 10);
    endfunction

    function automatic logic exp_en(input int v, input int i);
        return (i == 0) || (v >= pow10(i));
    endfunction

    // Drive one start on instance 1; returns at the negedge just after the
    // accepting edge T.
    task automatic launch(input logic [7:0] ia, input logic [7:0] ib);
        @(negedge clk);
        a = ia; b = ib; sel = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles after T until o_done is seen, -1 if it never arrives.
    task automatic wait_done(input int which, output int k);
        k = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((which == 0 && done === 1'b1) || (which == 1 && done2 === 1'b1)) begin
                k = n;
                break;
            end
        end
    endtask

    task automatic capture_scan(input int which);
        for (int n = 0; n < NCAP; n++) begin
            @(negedge clk);
            cap_sel[n] = (which == 0) ? dsel  : dsel2;
            cap_val[n] = (which == 0) ? value : value2;
            cap_en[n]  = (which == 0) ? en    : en2;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; sel = '0; a2 = '0; b2 = '0; sel2 = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got ready=%b busy=%b done=%b en=%b want 1 0 0 0", ready, busy, done, en);
        end
        total++;
        if (oa !== 8'd0 || ob !== 8'd0 || osel !== 2'd0 || dsel !== 2'd0 || value !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_data got a=%0d b=%0d sel=%0d dsel=%0d val=%0d want all 0", oa, ob, osel, dsel, value);
        end
        reset = 1'b0; reset2 = 1'b0;
        // Nothing has been computed yet, so every digit stays blank.
        capture_scan(0);
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_en[n] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_blank[%0d] got en=%b want 0", n, cap_en[n]);
            end
        end
    endtask

    task automatic test_basic;
        int k, run, changes;
        launch(8'd100, 8'd23);
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_exec got busy=%b ready=%b want 1 0", busy, ready);
        end
        wait_done(0, k);
        total++;
        if (k != 10) begin
            bad++;
            $display("[TB] FAIL basic_done_cycle got %0d want 10", k);
        end
        capture_scan(0);
        run = 1; changes = 0;
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_val[n] !== dig(123, int'(cap_sel[n])) || cap_en[n] !== exp_en(123, int'(cap_sel[n]))) begin
                bad++;
                $display("[TB] FAIL basic_scan[%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                         n, cap_sel[n], cap_val[n], cap_en[n], dig(123, int'(cap_sel[n])), exp_en(123, int'(cap_sel[n])));
            end
            if (n > 0) begin
                if (cap_sel[n] == cap_sel[n-1]) begin
                    run++;
                end else begin
                    total++;
                    if (cap_sel[n] !== cap_sel[n-1] + 2'd1 || (changes > 0 && run != REFRESH_DIV)) begin
                        bad++;
                        $display("[TB] FAIL basic_dwell[%0d] got sel=%0d after run=%0d want sel=%0d run=%0d",
                                 n, cap_sel[n], run, cap_sel[n-1] + 2'd1, REFRESH_DIV);
                    end
                    changes++;
                    run = 1;
                end
            end
        end
        total++;
        if (changes < 4) begin
            bad++;
            $display("[TB] FAIL basic_scan_moves got %0d digit changes want >=4", changes);
        end
    endtask

    task automatic test_small_values;
        int k;
        int vals [2] = '{7, 0};
        for (int t = 0; t < 2; t++) begin
            launch(8'(vals[t] == 7 ? 5 : 0), 8'(vals[t] == 7 ? 2 : 0));
            wait_done(0, k);
            total++;
            if (k != 10) begin
                bad++;
                $display("[TB] FAIL small_done_cycle v=%0d got %0d want 10", vals[t], k);
            end
            capture_scan(0);
            for (int n = 0; n < NCAP; n++) begin
                total++;
                if (cap_val[n] !== dig(vals[t], int'(cap_sel[n])) || cap_en[n] !== (cap_sel[n] == 2'd0)) begin
                    bad++;
                    $display("[TB] FAIL small_scan v=%0d [%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                             vals[t], n, cap_sel[n], cap_val[n], cap_en[n], dig(vals[t], int'(cap_sel[n])), cap_sel[n] == 2'd0);
                end
            end
        end
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        int first_k = -1;
        @(negedge clk);
        a = 8'd10; b = 8'd20; sel = 2'd2; start = 1'b1;
        @(negedge clk);
        a = 8'd77; b = 8'd88; sel = 2'd3;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL busy_ready got %b want 0", ready);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_k < 0) first_k = k;
            end
            if (k <= 9) begin
                total++;
                if (oa !== 8'd10 || ob !== 8'd20 || osel !== 2'd2) begin
                    bad++;
                    $display("[TB] FAIL busy_hold k=%0d got a=%0d b=%0d sel=%0d want 10 20 2", k, oa, ob, osel);
                end
            end
            if (k == 9) start = 1'b0;
        end
        total++;
        if (dones != 1 || first_k != 10) begin
            bad++;
            $display("[TB] FAIL busy_done got count=%0d at=%0d want 1 at 10", dones, first_k);
        end
        capture_scan(0);
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_val[n] !== dig(30, int'(cap_sel[n])) || cap_en[n] !== exp_en(30, int'(cap_sel[n]))) begin
                bad++;
                $display("[TB] FAIL busy_scan[%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                         n, cap_sel[n], cap_val[n], cap_en[n], dig(30, int'(cap_sel[n])), exp_en(30, int'(cap_sel[n])));
            end
        end
    endtask

    task automatic test_back_to_back;
        int k;
        bit seen = 1'b0;
        launch(8'd100, 8'd23);
        wait_done(0, k);
        @(negedge clk);
        launch(8'd200, 8'd55);
        // Old result must stay visible through the cycle o_done is seen.
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            total++;
            if (value !== dig(123, int'(dsel))) begin
                bad++;
                $display("[TB] FAIL b2b_hold n=%0d sel=%0d got val=%0d want %0d", n, dsel, value, dig(123, int'(dsel)));
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                total++;
                if (n != 10) begin
                    bad++;
                    $display("[TB] FAIL b2b_done_cycle got %0d want 10", n);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL b2b_done got none want one");
        end
        capture_scan(0);
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_val[n] !== dig(255, int'(cap_sel[n])) || cap_en[n] !== exp_en(255, int'(cap_sel[n]))) begin
                bad++;
                $display("[TB] FAIL b2b_scan[%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                         n, cap_sel[n], cap_val[n], cap_en[n], dig(255, int'(cap_sel[n])), exp_en(255, int'(cap_sel[n])));
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        int k;
        int dones = 0;
        launch(8'd50, 8'd60);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || en !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset got busy=%b en=%b done=%b ready=%b want 0 0 0 1", busy, en, done, ready);
        end
        reset = 1'b0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("[TB] FAIL midreset_nodone got %0d pulses want 0", dones);
        end
        launch(8'd9, 8'd9);
        wait_done(0, k);
        total++;
        if (k != 10) begin
            bad++;
            $display("[TB] FAIL midreset_done_cycle got %0d want 10", k);
        end
        capture_scan(0);
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_val[n] !== dig(18, int'(cap_sel[n])) || cap_en[n] !== exp_en(18, int'(cap_sel[n]))) begin
                bad++;
                $display("[TB] FAIL midreset_scan[%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                         n, cap_sel[n], cap_val[n], cap_en[n], dig(18, int'(cap_sel[n])), exp_en(18, int'(cap_sel[n])));
            end
        end
    endtask

    task automatic test_long_latency;
        int k;
        @(negedge clk);
        a2 = 8'd40; b2 = 8'd17; sel2 = 2'd0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(1, k);
        total++;
        if (k != 12) begin
            bad++;
            $display("[TB] FAIL latency_done_cycle got %0d want 12", k);
        end
        capture_scan(1);
        for (int n = 0; n < NCAP; n++) begin
            total++;
            if (cap_val[n] !== dig(57, int'(cap_sel[n])) || cap_en[n] !== exp_en(57, int'(cap_sel[n]))) begin
                bad++;
                $display("[TB] FAIL latency_scan[%0d] sel=%0d got val=%0d en=%b want val=%0d en=%b",
                         n, cap_sel[n], cap_val[n], cap_en[n], dig(57, int'(cap_sel[n])), exp_en(57, int'(cap_sel[n])));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_values();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_conv();
        test_long_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/calc_display_sequencer.md
Name: calc_display_sequencer

Overview:
Controller that sequences one calculator operation and shows its result on the 4-digit FND. It accepts operands and an operator through a start/ready handshake, drives the shared arithmetic datapath, and captures its binary result. It converts the result to BCD with an iterative shift-add-3 engine, then continuously time-multiplexes the digits into the BCD-to-FND decoder with leading-zero blanking.

Parameters:
DATA_W, 8, operand/result width; legal range 1..13 so the result fits 4 BCD digits
CALC_LAT, 1, clock cycles the datapath needs before i_result is valid (>=1)
REFRESH_DIV, 100000, clock cycles each digit stays selected

Ports:
i_clk  in  1  system clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  request valid; operands sampled when i_start && o_ready
o_ready  out  1  high in IDLE and SHOW
i_a  in  DATA_W  operand A
i_b  in  DATA_W  operand B
i_selOperator  in  2  operator code, passed through unchanged
o_a  out  DATA_W  latched operand A to datapath
o_b  out  DATA_W  latched operand B to datapath
o_selOperator  out  2  latched operator to datapath
i_result  in  DATA_W  datapath result
o_busy  out  1  high in EXEC and CONV
o_done  out  1  one-cycle pulse when a new result is loaded into the display
o_digitSelect  out  2  digit index to decoder, 0 = least significant
o_value  out  4  BCD nibble of the selected digit
o_en  out  1  decoder enable; low blanks the current digit

Behaviour:
- Reset: state IDLE; o_a, o_b, o_selOperator, o_busy, o_done, o_digitSelect, o_value, o_en = 0. Display register = 0, disp_valid = 0, refresh counter = 0. Reset at any time aborts the operation and blanks the display.
- FSM states: IDLE, EXEC, CONV, SHOW.
- IDLE/SHOW: if i_start, latch i_a/i_b/i_selOperator into o_a/o_b/o_selOperator at that edge (cycle T) and go to EXEC. Otherwise stay.
- EXEC: lasts exactly CALC_LAT cycles (T+1..T+CALC_LAT). i_result is sampled at the final EXEC edge into the shift register, BCD accumulator is cleared, and the state goes to CONV.
- CONV: DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. After the DATA_W-th shift, the state goes to SHOW.
- On entering SHOW (cycle T+CALC_LAT+DATA_W+1; T+10 with defaults): display register = 16-bit BCD, disp_valid = 1, and o_done = 1 for that cycle only.
- i_start is ignored while o_busy. o_a/o_b/o_selOperator hold stable from T+1 until the next accepted start.
- A start accepted in SHOW keeps the old display visible until the new o_done.
- Scan runs in every state:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments modulo 4 (3 wraps to 0).
  - Outputs are registered: o_digitSelect = index; o_value = nibble[index].
  - o_en = disp_valid && (index==0 || any nibble at position >= index is nonzero).
  - Result 0 therefore shows a single "0" on digit 0.

Decomposition:
- Shared package:
  - state enum {IDLE, EXEC, CONV, SHOW}
  - BCD_DIGITS = 4
  - NIBBLE_W = 4
  - width-check constant MAX_DATA_W = 13
- One natural sub-module: bin2bcd_seq. It takes load, DATA_W binary input, and outputs busy/done plus a 16-bit BCD result, and it owns the shift-add-3 iteration. The FSM and scanner remain in the top.

Test Plan:
- Datapath model returns a+b with CALC_LAT=1, REFRESH_DIV=4. Start with a=100, b=23 -> o_done at T+10; digits show 3,2,1; digit 3 has o_en=0; each digit lasts 4 cycles.
- a=5, b=2 -> display 7. o_en is high only when o_digitSelect=0. a=0, b=0 -> "0" on digit 0 only.
- Assert i_start during EXEC and CONV with different operands -> ignored; o_a/o_b unchanged; exactly one o_done.
- First result 123. Then in SHOW start with a=200, b=55 -> display stays 123 until the next o_done, then shows 255.
- Assert reset mid-CONV -> next cycle IDLE, o_busy=0, o_en=0, no o_done. A following start with a=9, b=9 -> display 18.
- Set CALC_LAT=3 and make the model output X until 3 cycles after launch -> the captured result is correct and o_done lands at T+12.
